// File: rtl/uart_rx_fsm_if.sv
// ============================================================================
// Module      : uart_rx_fsm_if
// Description : Bundles rx line, sampler, parity-checker and frame-output
//               signals between the UART RX frame controller and its peers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_rx_fsm_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
);
    logic                      rx_in;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic                      par_en;
    logic                      sampled_bit;
    logic                      par_error;
    logic                      dat_samp_en;
    logic [PRESCALE_WIDTH-1:0] edge_cnt;
    logic [DATA_WIDTH-1:0]     p_data;
    logic                      par_chk_en;
    logic                      stp_err;
    logic                      data_valid;

    // Environment side: line, configuration, sampler and parity checker.
    modport master (
        output rx_in, prescale, par_en, sampled_bit, par_error,
        input  dat_samp_en, edge_cnt, p_data, par_chk_en, stp_err, data_valid
    );

    // Frame controller side.
    modport slave (
        input  rx_in, prescale, par_en, sampled_bit, par_error,
        output dat_samp_en, edge_cnt, p_data, par_chk_en, stp_err, data_valid
    );
endinterface

`default_nettype wire

// File: rtl/uart_rx_fsm.sv
// ============================================================================
// Module      : uart_rx_fsm
// Description : UART receive frame controller; walks start/data/parity/stop
//               bits, deserializes LSB-first and flags good frames.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_fsm #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input wire          clk,
    input wire          rst,
    uart_rx_fsm_if.slave bus
);

    localparam int c_bit_cnt_w = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t                    r_state,       w_nxt_state;
    logic [PRESCALE_WIDTH-1:0] r_edge,        w_nxt_edge;
    logic [c_bit_cnt_w-1:0]    r_bit_cnt,     w_nxt_bit_cnt;
    logic [DATA_WIDTH-1:0]     r_p_data,      w_nxt_p_data;
    logic                      r_par_en,      w_nxt_par_en;
    logic                      r_stp_err,     w_nxt_stp_err;
    logic                      r_data_valid,  w_nxt_data_valid;
    logic                      r_par_chk_en,  w_nxt_par_chk_en;
    logic                      r_dat_samp_en;

    logic [PRESCALE_WIDTH-1:0] w_samp_pt;
    logic [PRESCALE_WIDTH-1:0] w_last;
    logic                      w_at_samp;
    logic                      w_at_last;

    // Sampler votes around mid and registers, so its result is usable at mid+2.
    assign w_samp_pt = (bus.prescale >> 1) + PRESCALE_WIDTH'(2);
    assign w_last    = bus.prescale - PRESCALE_WIDTH'(1);
    assign w_at_samp = (r_edge == w_samp_pt);
    assign w_at_last = (r_edge == w_last);

    always_comb begin
        w_nxt_state      = r_state;
        w_nxt_bit_cnt    = r_bit_cnt;
        w_nxt_p_data     = r_p_data;
        w_nxt_par_en     = r_par_en;
        w_nxt_stp_err    = r_stp_err;
        w_nxt_data_valid = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (!bus.rx_in) begin
                    w_nxt_state   = ST_START;
                    w_nxt_par_en  = bus.par_en;
                    w_nxt_stp_err = 1'b0;
                end
            end
            ST_START: begin
                if (w_at_samp && bus.sampled_bit) begin
                    w_nxt_state = ST_IDLE;
                end else if (w_at_last) begin
                    w_nxt_state   = ST_DATA;
                    w_nxt_bit_cnt = '0;
                end
            end
            ST_DATA: begin
                if (w_at_samp) begin
                    w_nxt_p_data = {bus.sampled_bit, r_p_data[DATA_WIDTH-1:1]};
                end
                if (w_at_last) begin
                    w_nxt_bit_cnt = r_bit_cnt + c_bit_cnt_w'(1);
                    if (r_bit_cnt == c_bit_cnt_w'(DATA_WIDTH - 1)) begin
                        w_nxt_state = r_par_en ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (w_at_last) begin
                    w_nxt_state = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_at_samp) begin
                    w_nxt_stp_err = ~bus.sampled_bit;
                end
                if (w_at_last) begin
                    w_nxt_data_valid = !r_stp_err && (!r_par_en || !bus.par_error);
                    // A low line here is already the next start bit.
                    if (!bus.rx_in) begin
                        w_nxt_state   = ST_START;
                        w_nxt_par_en  = bus.par_en;
                        w_nxt_stp_err = 1'b0;
                    end else begin
                        w_nxt_state = ST_IDLE;
                    end
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_nxt_edge = '0;
        if (r_state != ST_IDLE && w_nxt_state != ST_IDLE && !w_at_last) begin
            w_nxt_edge = r_edge + PRESCALE_WIDTH'(1);
        end
        w_nxt_par_chk_en = (w_nxt_state == ST_PARITY) && (w_nxt_edge == w_samp_pt);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_edge        <= '0;
            r_bit_cnt     <= '0;
            r_p_data      <= '0;
            r_par_en      <= 1'b0;
            r_stp_err     <= 1'b0;
            r_data_valid  <= 1'b0;
            r_par_chk_en  <= 1'b0;
            r_dat_samp_en <= 1'b0;
        end else begin
            r_state       <= w_nxt_state;
            r_edge        <= w_nxt_edge;
            r_bit_cnt     <= w_nxt_bit_cnt;
            r_p_data      <= w_nxt_p_data;
            r_par_en      <= w_nxt_par_en;
            r_stp_err     <= w_nxt_stp_err;
            r_data_valid  <= w_nxt_data_valid;
            r_par_chk_en  <= w_nxt_par_chk_en;
            r_dat_samp_en <= (w_nxt_state != ST_IDLE);
        end
    end

    assign bus.dat_samp_en = r_dat_samp_en;
    assign bus.edge_cnt    = r_edge;
    assign bus.p_data      = r_p_data;
    assign bus.par_chk_en  = r_par_chk_en;
    assign bus.stp_err     = r_stp_err;
    assign bus.data_valid  = r_data_valid;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fsm.sv
// ============================================================================
// Module      : tb_uart_rx_fsm
// Description : Self-checking bench for uart_rx_fsm with sampler/parity models
//               and a frame-level scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx_fsm;

    localparam int DW = 8;
    localparam int PW = 6;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   par_seen = 0;
    int   par_exp  = 0;
    logic [7:0] m_pdata = 8'h00;
    exp_t q[$];

    uart_rx_fsm_if #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) bus ();

    uart_rx_fsm #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Data sampler (3-vote majority around mid) and even-parity checker models.
    logic v0, v1;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            v0              <= 1'b1;
            v1              <= 1'b1;
            bus.sampled_bit <= 1'b1;
            bus.par_error   <= 1'b0;
        end else begin
            if (bus.dat_samp_en) begin
                if (bus.edge_cnt == (bus.prescale >> 1) - 1) v0 <= bus.rx_in;
                if (bus.edge_cnt == (bus.prescale >> 1))     v1 <= bus.rx_in;
                if (bus.edge_cnt == (bus.prescale >> 1) + 1)
                    bus.sampled_bit <= (v0 & v1) | (v0 & bus.rx_in) | (v1 & bus.rx_in);
            end
            if (bus.par_chk_en) bus.par_error <= ^{bus.p_data, bus.sampled_bit};
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (bus.data_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected data_valid: p_data %0h, no frame expected", bus.p_data);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("valid p_data", bus.p_data, e.data);
                    check("valid cycle", cyc, e.cyc);
                end
            end
            if (bus.par_chk_en) begin
                par_seen++;
                check("par_chk_en edge", bus.edge_cnt, (bus.prescale >> 1) + 2);
            end
        end
    end

    task automatic drive_bit(input logic b, input int p);
        bus.rx_in = b;
        repeat (p) @(negedge clk);
    endtask

    task automatic check_reset_outputs();
        check("rst dat_samp_en", bus.dat_samp_en, 0);
        check("rst edge_cnt",    bus.edge_cnt,    0);
        check("rst p_data",      bus.p_data,      0);
        check("rst par_chk_en",  bus.par_chk_en,  0);
        check("rst stp_err",     bus.stp_err,     0);
        check("rst data_valid",  bus.data_valid,  0);
    endtask

    // One frame; abort_after>0 resets the DUT before that data bit.
    task automatic send_frame(input logic [7:0] d, input int p, input bit pe,
                              input bit flip, input bit stop_ok, input int gap_bits,
                              input int abort_after);
        exp_t e;
        bit   good;
        bus.prescale = PW'(p);
        bus.par_en   = pe;
        good   = stop_ok && !(pe && flip);
        e.data = d;
        e.cyc  = cyc + 1 + (10 + int'(pe)) * p;
        if (abort_after == 0 && good) q.push_back(e);
        drive_bit(1'b0, p);
        check("stp_err cleared at start", bus.stp_err, 0);
        bus.par_en = 1'($urandom_range(0, 1));
        for (int i = 0; i < 8; i++) begin
            if (abort_after != 0 && i == abort_after) begin
                rst = 1'b0;
                #1;
                check_reset_outputs();
                @(negedge clk);
                check_reset_outputs();
                rst        = 1'b1;
                bus.rx_in  = 1'b1;
                m_pdata    = 8'h00;
                repeat (2 * p) @(negedge clk);
                check("post-abort p_data", bus.p_data, m_pdata);
                return;
            end
            drive_bit(d[i], p);
        end
        m_pdata = d;
        if (pe) begin
            drive_bit(^d ^ flip, p);
            par_exp++;
        end
        drive_bit(stop_ok, p);
        check("stp_err", bus.stp_err, !stop_ok);
        check("p_data after frame", bus.p_data, m_pdata);
        if (gap_bits > 0) drive_bit(1'b1, gap_bits * p);
    endtask

    task automatic glitch();
        bus.prescale = PW'(8);
        drive_bit(1'b0, 3);
        drive_bit(1'b1, 16);
        check("glitch p_data", bus.p_data, m_pdata);
        check("glitch idle samp_en", bus.dat_samp_en, 0);
        check("glitch idle edge", bus.edge_cnt, 0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        int gap;
        int prev_gap;
        rst          = 1'b0;
        bus.rx_in    = 1'b1;
        bus.prescale = PW'(8);
        bus.par_en   = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);

        send_frame(8'hA5, 8,  1'b0, 1'b0, 1'b1, 2, 0);
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 2, 0);
        send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1, 2, 0);
        glitch();
        send_frame(8'h55, 32, 1'b0, 1'b0, 1'b0, 2, 0);
        send_frame(8'h96, 32, 1'b0, 1'b0, 1'b1, 2, 0);
        send_frame(8'h01, 8,  1'b0, 1'b0, 1'b1, 0, 0);
        send_frame(8'hFE, 8,  1'b0, 1'b0, 1'b1, 0, 4);

        p        = 8;
        prev_gap = 1;
        for (int n = 0; n < 24; n++) begin
            if (prev_gap > 0) p = 8 << $urandom_range(0, 2);
            gap = $urandom_range(0, 2);
            send_frame(8'($urandom), p, 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0), gap, 0);
            prev_gap = gap;
        end
        drive_bit(1'b1, 3 * 32);

        check("scoreboard drained", q.size(), 0);
        check("par_chk_en pulses", par_seen, par_exp);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
